// File: rtl/sprint_ctrl_pkg.sv
// Shared types and helpers for the Sprint1 steering quadrature emulation.
package sprint_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // Quadrature phases in right-turn order; left walks the list backwards.
    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b10;

    // One Gray step from the given phase; dir=1 is right, dir=0 is left.
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
        logic [1:0] nxt;
        nxt = PH0;
        case (phase)
            PH0:     nxt = dir ? PH1 : PH3;
            PH1:     nxt = dir ? PH2 : PH0;
            PH2:     nxt = dir ? PH3 : PH1;
            PH3:     nxt = dir ? PH0 : PH2;
            default: nxt = PH0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/steer_quad_ctrl_if.sv
// Joystick request / step-rate configuration inputs and quadrature outputs.
interface steer_quad_ctrl_if #(
    parameter int DIV_W  = 16,
    parameter int RAMP_W = 8
);
    logic              left;
    logic              right;
    logic [DIV_W-1:0]  period_start;
    logic [DIV_W-1:0]  period_min;
    logic [RAMP_W-1:0] ramp_dec;
    logic [1:0]        steer;
    logic              moving;
    logic              dir;
    logic              step_pulse;

    // Joystick mapping side: drives requests and rate settings.
    modport master (
        output left, right, period_start, period_min, ramp_dec,
        input  steer, moving, dir, step_pulse
    );

    // Controller side.
    modport slave (
        input  left, right, period_start, period_min, ramp_dec,
        output steer, moving, dir, step_pulse
    );
endinterface

// File: rtl/steer_rate_ramp.sv
// Step-rate generator: counts cycles since the last step and shortens the
// step period after every step down to a floor.
module steer_rate_ramp #(
    parameter int DIV_W  = 16,
    parameter int RAMP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              run,
    input  logic [DIV_W-1:0]  period_start,
    input  logic [DIV_W-1:0]  period_min,
    input  logic [RAMP_W-1:0] ramp_dec,
    output logic              step_due
);

    logic [DIV_W-1:0] counter_q;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] period_eff;
    logic [DIV_W-1:0] fmin_raw;
    logic [DIV_W-1:0] fmin_eff;
    logic [DIV_W-1:0] ramp_ext;
    logic [DIV_W-1:0] sat_sub;
    logic [DIV_W-1:0] next_period;

    // A zero period would never match the counter, so it behaves as one cycle.
    assign period_eff = (period_q == '0) ? DIV_W'(1) : period_q;
    assign fmin_raw   = (period_min >= period_start) ? period_start : period_min;
    assign fmin_eff   = (fmin_raw == '0) ? DIV_W'(1) : fmin_raw;
    assign ramp_ext   = DIV_W'(ramp_dec);

    // Saturating period decrement, clamped up to the cruise floor.
    always_comb begin
        sat_sub     = '0;
        next_period = fmin_eff;
        if (period_eff > ramp_ext) begin
            sat_sub = period_eff - ramp_ext;
        end
        if (sat_sub > fmin_eff) begin
            next_period = sat_sub;
        end
    end

    // ">=" rather than "==" so a live shrink of the period steps next cycle.
    assign step_due = run && (counter_q >= (period_eff - DIV_W'(1)));

    // Counter and period register; load wins over step, step over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
            period_q  <= '0;
        end else if (load) begin
            counter_q <= '0;
            period_q  <= period_start;
        end else if (step) begin
            counter_q <= '0;
            period_q  <= next_period;
        end else if (run) begin
            counter_q <= counter_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/steer_quad_ctrl.sv
// Steering quadrature encoder emulation: turns left/right joystick requests
// into a ramping-rate two-phase SteerA/SteerB stream for the Sprint1 core.
module steer_quad_ctrl #(
    parameter int DIV_W  = 16,
    parameter int RAMP_W = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    steer_quad_ctrl_if.slave bus
);
    import sprint_ctrl_pkg::*;

    state_t     state_q;
    state_t     state_d;
    logic       req_r;
    logic       req_l;
    logic       any_req;
    logic [1:0] steer_q;
    logic       dir_q;
    logic       pulse_q;
    logic       do_step;
    logic       step_dir;
    logic       ramp_load;
    logic       ramp_step;
    logic       ramp_run;
    logic       step_due;

    assign any_req = req_r | req_l;

    // Register the decoded request once; both or neither pressed means none.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            req_r <= 1'b0;
            req_l <= 1'b0;
        end else begin
            req_r <= bus.right & ~bus.left;
            req_l <= bus.left & ~bus.right;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, step decision and rate-generator control.
    always_comb begin
        state_d   = state_q;
        do_step   = 1'b0;
        step_dir  = dir_q;
        ramp_load = 1'b0;
        ramp_step = 1'b0;
        ramp_run  = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                ramp_load = 1'b1;
                if (any_req) begin
                    do_step  = 1'b1;
                    step_dir = req_r;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                ramp_run = 1'b1;
                if (!any_req) begin
                    state_d   = IDLE;
                    ramp_load = 1'b1;
                end else if (req_r != dir_q) begin
                    state_d   = TURN;
                    ramp_load = 1'b1;
                end else if (step_due) begin
                    do_step   = 1'b1;
                    ramp_step = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Phase, direction and strobe; phase only ever moves one Gray step.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            steer_q <= PH0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= do_step;
            if (do_step) begin
                steer_q <= next_phase(steer_q, step_dir);
                dir_q   <= step_dir;
            end
        end
    end

    steer_rate_ramp #(
        .DIV_W  (DIV_W),
        .RAMP_W (RAMP_W)
    ) u_ramp (
        .clk          (CLK),
        .rst_n        (Reset_n),
        .load         (ramp_load),
        .step         (ramp_step),
        .run          (ramp_run),
        .period_start (bus.period_start),
        .period_min   (bus.period_min),
        .ramp_dec     (bus.ramp_dec),
        .step_due     (step_due)
    );

    assign bus.steer      = steer_q;
    assign bus.moving     = (state_q == RUN);
    assign bus.dir        = dir_q;
    assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_steer_quad_ctrl.sv
// Randomised scoreboard bench for steer_quad_ctrl with an elapsed-time model.
module tb_steer_quad_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_TURN = 2;

    typedef struct {
        int         cyc;
        logic [1:0] steer;
        logic       dir;
    } exp_t;

    logic CLK;
    logic Reset_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    exp_t       exp_q[$];
    exp_t       got;
    logic       exp_step;
    logic [1:0] phase_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    int   m_mode   = M_IDLE;
    int   m_phase  = 0;
    logic m_dir    = 1'b0;
    int   m_req    = 0;
    int   m_last   = 0;
    int   m_period = 1;

    steer_quad_ctrl_if #(.DIV_W(16), .RAMP_W(8)) bus ();

    steer_quad_ctrl #(.DIV_W(16), .RAMP_W(8)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic l, input logic r, input int n);
        bus.left  = l;
        bus.right = r;
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_periods(input int ps, input int pm, input int rd);
        bus.period_start = 16'(ps);
        bus.period_min   = 16'(pm);
        bus.ramp_dec     = 8'(rd);
    endtask

    // Record a predicted step: new phase, direction and period from the rules.
    task automatic model_step(input logic d, input bit fresh);
        int ps, pm, rd, fm, p;
        exp_t e;
        ps = int'(bus.period_start);
        pm = int'(bus.period_min);
        rd = int'(bus.ramp_dec);
        if (fresh) begin
            m_period = (ps == 0) ? 1 : ps;
        end else begin
            fm = (pm >= ps) ? ps : pm;
            if (fm == 0) fm = 1;
            p = m_period - rd;
            m_period = (p < fm) ? fm : p;
        end
        m_phase = d ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
        m_dir   = d;
        m_mode  = M_RUN;
        m_last  = cyc;
        e.cyc   = cyc;
        e.steer = phase_tab[m_phase];
        e.dir   = d;
        exp_q.push_back(e);
    endtask

    // Reference model: steps are decided from cycles elapsed since the last step.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (!Reset_n) begin
            m_mode  = M_IDLE;
            m_phase = 0;
            m_dir   = 1'b0;
            m_req   = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_TURN: begin
                    if (m_req != 0) model_step(m_req == 1, 1'b1);
                    else m_mode = M_IDLE;
                end
                default: begin
                    if (m_req == 0) m_mode = M_IDLE;
                    else if ((m_req == 1) != m_dir) m_mode = M_TURN;
                    else if (cyc - m_last >= m_period) model_step(m_dir, 1'b0);
                end
            endcase
            m_req = (bus.right && !bus.left) ? 1 : ((bus.left && !bus.right) ? 2 : 0);
        end
    end

    // Monitor: every cycle compare the strobe, and on each step pop and compare.
    always @(posedge CLK) begin
        #1;
        exp_step = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check_output("step_pulse", int'(bus.step_pulse), int'(exp_step));
        if (exp_step) begin
            got = exp_q.pop_front();
            check_output("step_phase", int'(bus.steer), int'(got.steer));
            check_output("step_dir", int'(bus.dir), int'(got.dir));
        end
        check_output("moving", int'(bus.moving), (m_mode == M_RUN) ? 1 : 0);
    end

    initial begin
        Reset_n   = 1'b0;
        bus.left  = 1'b0;
        bus.right = 1'b0;
        set_periods(100, 40, 20);
        repeat (3) @(negedge CLK);
        check_output("reset_steer", int'(bus.steer), 0);
        check_output("reset_moving", int'(bus.moving), 0);
        check_output("reset_dir", int'(bus.dir), 0);
        check_output("reset_pulse", int'(bus.step_pulse), 0);
        Reset_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 3);

        // Single-cycle right tap gives exactly one step.
        apply_stimulus(1'b0, 1'b1, 1);
        apply_stimulus(1'b0, 1'b0, 10);
        check_output("tap_steer", int'(bus.steer), 1);
        check_output("tap_dir", int'(bus.dir), 1);
        check_output("tap_moving", int'(bus.moving), 0);

        // Held right ramps the rate, then reverse through a turn.
        apply_stimulus(1'b0, 1'b1, 420);
        apply_stimulus(1'b1, 1'b0, 150);
        apply_stimulus(1'b0, 1'b0, 5);
        check_output("turn_dir", int'(bus.dir), 0);

        // Both pressed: nothing from idle, and a stop from run.
        apply_stimulus(1'b1, 1'b1, 20);
        check_output("both_idle_moving", int'(bus.moving), 0);
        apply_stimulus(1'b0, 1'b1, 50);
        apply_stimulus(1'b1, 1'b1, 20);
        check_output("both_run_moving", int'(bus.moving), 0);
        apply_stimulus(1'b0, 1'b0, 5);

        // Floor above start, oversized decrement, then a zero period.
        set_periods(50, 200, 255);
        apply_stimulus(1'b0, 1'b1, 300);
        apply_stimulus(1'b0, 1'b0, 5);
        set_periods(0, 0, 0);
        apply_stimulus(1'b0, 1'b1, 12);
        apply_stimulus(1'b0, 1'b0, 5);

        // Async reset in the middle of a run at phase 10.
        set_periods(100, 40, 20);
        Reset_n = 1'b0;
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, 200);
        check_output("pre_reset_steer", int'(bus.steer), 2);
        @(posedge CLK);
        #2;
        Reset_n = 1'b0;
        #1;
        check_output("async_steer", int'(bus.steer), 0);
        check_output("async_moving", int'(bus.moving), 0);
        check_output("async_pulse", int'(bus.step_pulse), 0);
        check_output("async_dir", int'(bus.dir), 0);
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, 4);
        check_output("post_reset_steer", int'(bus.steer), 1);
        apply_stimulus(1'b0, 1'b0, 5);

        // Random requests with live rate changes.
        for (int i = 0; i < 40; i++) begin
            set_periods($urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 12));
            apply_stimulus(1'($urandom % 2), 1'($urandom % 2), $urandom_range(1, 60));
        end
        apply_stimulus(1'b0, 1'b0, 10);

        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
